// File: rtl/layer_boundary_skid_reg.sv
// ============================================================================
// Module      : layer_boundary_skid_reg
// Description : Two-entry valid/ready skid stage between two LUT-neuron
//               layers. It carries the activation vector and its image tag,
//               drives the next layer from a registered main entry, and
//               counts delivered images for debug.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_boundary_skid_reg #(
   parameter int WIDTH = 256,
   parameter int TAG_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,        // asynchronous, active-low
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic [TAG_W-1:0] s_tag,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [TAG_W-1:0] m_tag,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] img_count
);

   // The state value is the number of held entries, so it doubles as the
   // occupancy output.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic               s_ready_q,   s_ready_d;
   logic               m_valid_q,   m_valid_d;
   logic [WIDTH-1:0]   main_data_q, main_data_d;
   logic [TAG_W-1:0]   main_tag_q,  main_tag_d;
   logic [WIDTH-1:0]   skid_data_q, skid_data_d;
   logic [TAG_W-1:0]   skid_tag_q,  skid_tag_d;
   logic [CNT_W-1:0]   img_count_q, img_count_d;

   logic               w_accept;
   logic               w_deliver;

   // Handshakes are judged only on registered flags, so s_ready never
   // depends combinationally on m_ready.
   assign w_accept  = s_valid   & s_ready_q;
   assign w_deliver = m_valid_q & m_ready;

   // Next-state for occupancy and both storage entries; flush wins over any
   // concurrent accept or deliver but leaves the stored payload untouched.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_tag_d  = main_tag_q;
      skid_data_d = skid_data_q;
      skid_tag_d  = skid_tag_q;

      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (w_accept) begin
                  main_data_d = s_data;
                  main_tag_d  = s_tag;
                  state_d     = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && !w_deliver) begin
                  // Downstream stalled: park the new vector in the skid slot.
                  skid_data_d = s_data;
                  skid_tag_d  = s_tag;
                  state_d     = ST_TWO;
               end else if (w_accept && w_deliver) begin
                  main_data_d = s_data;
                  main_tag_d  = s_tag;
               end else if (w_deliver) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // s_ready is low here, so only a deliver can happen.
               if (w_deliver) begin
                  main_data_d = skid_data_q;
                  main_tag_d  = skid_tag_q;
                  state_d     = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Handshake flags follow the next occupancy so they are valid registers.
   always_comb begin
      m_valid_d   = (state_d != ST_EMPTY);
      s_ready_d   = (state_d != ST_TWO);
      // A deliver during flush still counts: downstream saw a handshake.
      img_count_d = img_count_q + CNT_W'(w_deliver);
   end

   // State and storage registers; reset discards everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         s_ready_q   <= 1'b0;
         m_valid_q   <= 1'b0;
         main_data_q <= '0;
         main_tag_q  <= '0;
         skid_data_q <= '0;
         skid_tag_q  <= '0;
         img_count_q <= '0;
      end else begin
         state_q     <= state_d;
         s_ready_q   <= s_ready_d;
         m_valid_q   <= m_valid_d;
         main_data_q <= main_data_d;
         main_tag_q  <= main_tag_d;
         skid_data_q <= skid_data_d;
         skid_tag_q  <= skid_tag_d;
         img_count_q <= img_count_d;
      end
   end

   assign s_ready   = s_ready_q;
   assign m_valid   = m_valid_q;
   assign m_data    = main_data_q;
   assign m_tag     = main_tag_q;
   assign occupancy = state_q;
   assign img_count = img_count_q;

endmodule

`default_nettype wire
